// File: rtl/note_judge_pkg.sv
// Shared constants, state encoding and helpers for the note_judge rhythm-game judge.
package note_judge_pkg;

   localparam int LANES_DEF   = 5;
   localparam int DEPTH_DEF   = 8;
   localparam int SCORE_W_DEF = 16;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_PLAY  = 2'd1,
      ST_DRAIN = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   localparam logic [7:0] COMBO_BONUS_TH = 8'd8;
   localparam logic [7:0] PTS_BASE       = 8'd1;
   localparam logic [7:0] PTS_BONUS      = 8'd2;
   localparam logic [7:0] COMBO_MAX      = 8'd255;
   localparam logic [7:0] MISS_MAX       = 8'd255;

   // Number of set bits; lane vectors are zero-extended to 32 bits by the caller.
   function automatic logic [7:0] popcount(input logic [31:0] v);
      logic [7:0] n;
      n = '0;
      for (int i = 0; i < 32; i++) begin
         n = n + 8'(v[i]);
      end
      return n;
   endfunction

endpackage

// File: rtl/note_judge_edge.sv
// lane_edge_detect: per-lane rising-edge detector for debounced player buttons.
module lane_edge_detect
   import note_judge_pkg::*;
#(
   parameter int LANES = LANES_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [LANES-1:0] btn,
   output logic [LANES-1:0] press
);

   logic [LANES-1:0] prev_q;

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         prev_q <= '0;
      end else begin
         prev_q <= btn;
      end
   end

   assign press = btn & ~prev_q;

endmodule

// File: rtl/note_judge.sv
// note_judge: scrolls chart notes down a LANES x DEPTH field and judges presses at the hit row.
// Build option: NOTE_JUDGE_GHOST_PENALTY_EN makes a press on an empty hit-row lane break the combo.
module note_judge
   import note_judge_pkg::*;
#(
   parameter int LANES   = LANES_DEF,
   parameter int DEPTH   = DEPTH_DEF,
   parameter int SCORE_W = SCORE_W_DEF
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     start,
   input  logic                     song_end,
   input  logic                     step,
   input  logic [LANES-1:0]         key_in,
   input  logic [LANES-1:0]         btn,
   output logic [LANES*DEPTH-1:0]   field,
   output logic                     hit_pulse,
   output logic                     miss_pulse,
   output logic [SCORE_W-1:0]       score,
   output logic [7:0]               combo,
   output logic [7:0]               max_combo,
   output logic [7:0]               miss_count,
   output logic [1:0]               state
);

   localparam int DRAIN_W = $clog2(DEPTH) + 1;

   state_t               st_q, st_d;
   logic [LANES-1:0]     rows_q [DEPTH];
   logic [LANES-1:0]     rows_d [DEPTH];
   logic [SCORE_W-1:0]   score_q, score_d;
   logic [7:0]           combo_q, combo_d;
   logic [7:0]           max_q, max_d;
   logic [7:0]           miss_q, miss_d;
   logic                 hit_q, hit_d;
   logic                 missp_q, missp_d;
   logic [DRAIN_W-1:0]   drain_q, drain_d;

   logic [LANES-1:0]     press;
   logic                 judge;
   logic [LANES-1:0]     hit_row, hits, row_after, misses;
   logic [7:0]           hit_n, miss_n;
   logic [7:0]           pts;
   logic [15:0]          points;
   logic [SCORE_W:0]     score_sum;
   logic [8:0]           combo_sum, miss_sum;
   logic [7:0]           combo_hit;
   logic                 ghost_hit;

   lane_edge_detect #(.LANES(LANES)) u_edge (
      .clk   (clk),
      .rst   (rst),
      .btn   (btn),
      .press (press)
   );

   assign judge     = (st_q == ST_PLAY) || (st_q == ST_DRAIN);
   assign hit_row   = rows_q[DEPTH-1];
   assign hits      = judge ? (press & hit_row) : '0;
   assign row_after = hit_row & ~hits;
   assign misses    = (judge && step) ? row_after : '0;
   assign hit_n     = popcount(32'(hits));
   assign miss_n    = popcount(32'(misses));

`ifdef NOTE_JUDGE_GHOST_PENALTY_EN
   assign ghost_hit = judge && |(press & ~hit_row);
`else
   assign ghost_hit = 1'b0;
`endif

   // Bonus is decided by the combo held before this cycle's hits.
   assign pts       = (combo_q >= COMBO_BONUS_TH) ? PTS_BONUS : PTS_BASE;
   assign points    = 16'(hit_n) * 16'(pts);
   assign score_sum = (SCORE_W+1)'(score_q) + (SCORE_W+1)'(points);
   assign combo_sum = {1'b0, combo_q} + {1'b0, hit_n};
   assign miss_sum  = {1'b0, miss_q} + {1'b0, miss_n};
   assign combo_hit = (combo_sum > {1'b0, COMBO_MAX}) ? COMBO_MAX : combo_sum[7:0];

   // NOTE: every always_comb target gets a default first so no path leaves a latch behind.
   always_comb begin
      st_d    = st_q;
      rows_d  = rows_q;
      score_d = score_q;
      combo_d = combo_q;
      max_d   = max_q;
      miss_d  = miss_q;
      hit_d   = 1'b0;
      missp_d = 1'b0;
      drain_d = drain_q;

      if (start) begin
         st_d    = ST_PLAY;
         score_d = '0;
         combo_d = '0;
         max_d   = '0;
         miss_d  = '0;
         drain_d = '0;
         for (int r = 0; r < DEPTH; r++) rows_d[r] = '0;
      end else begin
         unique case (st_q)
            ST_PLAY, ST_DRAIN: begin
               rows_d[DEPTH-1] = row_after;
               if (step) begin
                  for (int r = DEPTH-1; r > 0; r--) rows_d[r] = rows_q[r-1];
                  rows_d[0] = (st_q == ST_PLAY) ? key_in : '0;
               end

               score_d = score_sum[SCORE_W] ? '1 : score_sum[SCORE_W-1:0];
               combo_d = combo_hit;
               if (miss_n != 8'd0 || ghost_hit) combo_d = '0;
               if (miss_n != 8'd0)
                  miss_d = (miss_sum > {1'b0, MISS_MAX}) ? MISS_MAX : miss_sum[7:0];
               max_d   = (combo_d > max_q) ? combo_d : max_q;
               hit_d   = (hits != '0);
               missp_d = (misses != '0) || ghost_hit;

               if (st_q == ST_PLAY) begin
                  if (song_end) begin
                     st_d    = ST_DRAIN;
                     drain_d = '0;
                  end
               end else if (step) begin
                  drain_d = drain_q + 1'b1;
                  if (drain_q == DRAIN_W'(DEPTH-1)) st_d = ST_DONE;
               end
            end
            default: begin
               for (int r = 0; r < DEPTH; r++) rows_d[r] = '0;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         st_q    <= ST_IDLE;
         score_q <= '0;
         combo_q <= '0;
         max_q   <= '0;
         miss_q  <= '0;
         hit_q   <= 1'b0;
         missp_q <= 1'b0;
         drain_q <= '0;
         for (int r = 0; r < DEPTH; r++) rows_q[r] <= '0;
      end else begin
         st_q    <= st_d;
         score_q <= score_d;
         combo_q <= combo_d;
         max_q   <= max_d;
         miss_q  <= miss_d;
         hit_q   <= hit_d;
         missp_q <= missp_d;
         drain_q <= drain_d;
         rows_q  <= rows_d;
      end
   end

   for (genvar r = 0; r < DEPTH; r++) begin : g_field
      assign field[r*LANES +: LANES] = rows_q[r];
   end

   assign hit_pulse  = hit_q;
   assign miss_pulse = missp_q;
   assign score      = score_q;
   assign combo      = combo_q;
   assign max_combo  = max_q;
   assign miss_count = miss_q;
   assign state      = st_q;

endmodule

// File: doc/note_judge.md
# note_judge

Downstream consumer of the chart sequencer's per-step lane vector. Scrolls chart notes through a LANES×DEPTH falling field and judges player button presses at the bottom hit row. Maintains score, combo, max combo and miss count for the display/score stage. A small FSM brackets one song: idle, play, drain and done.

## Interface
- LANES, 5: number of note lanes; matches the chart's one-hot key width.
- DEPTH, 8: rows in the field; row 0 is the top (entry), row DEPTH-1 is the hit row.
- SCORE_W, 16: score counter width.
- clk  in  1  single system clock, rising edge.
- rst  in  1  reset, synchronous, active-high.
- start  in  1  one-cycle pulse that begins (or restarts) a song.
- song_end  in  1  one-cycle pulse marking the last chart step.
- step  in  1  one-cycle pulse per chart step (scroll tick).
- key_in  in  LANES  chart lane vector; sampled only on step.
- btn  in  LANES  debounced player buttons, level.
- field  out  LANES*DEPTH  note field, row r at bits [r*LANES +: LANES].
- hit_pulse  out  1  one cycle; at least one lane hit this cycle.
- miss_pulse  out  1  one cycle; at least one note missed this cycle.
- score  out  SCORE_W  accumulated score.
- combo  out  8  current consecutive-hit count.
- max_combo  out  8  largest combo reached this song.
- miss_count  out  8  missed notes this song, saturating.
- state  out  2  IDLE=0, PLAY=1, DRAIN=2, DONE=3.

## Operation
- Reset: field=0, all counters=0, pulses=0, state=IDLE, button history=0.
- IDLE: field held at 0. step and btn are ignored. start → PLAY and clears score, combo, max_combo and miss_count.
- PLAY: on step, rows shift down by one and row 0 loads key_in. song_end → DRAIN with drain count=0.
- DRAIN: on step, row 0 loads 0 instead of key_in and drain count increments. After DEPTH steps → DONE.
- DONE: field is 0 and counters are frozen. start → PLAY with cleared counters.
- start in PLAY or DRAIN restarts immediately: field and counters are cleared and state=PLAY.
- Press = rising edge of btn[l], taken against the previous-cycle sample. Presses are judged only in PLAY and DRAIN.
- Hit: a press in lane l while the hit row bit l=1. That bit is cleared, so the note cannot later count as a miss.
- Ghost press: a press in lane l while the hit row bit l=0. Effect is set by configuration.
- Miss: on step, each hit-row bit still set when the row shifts out counts as one miss.
- Score per hit: +2 if combo≥8 before this cycle, else +1. Score saturates at 2^SCORE_W−1.
- Multiple hits in one cycle sum their points; combo increases by the hit count and saturates at 255.
- Any miss in a cycle: combo=0 and miss_count increases by the miss count, saturating at 255.
- max_combo = max(max_combo, new combo), updated every cycle.

## Timing
- All outputs are registered. A step or press affects outputs on the next rising edge: 1-cycle latency.
- Press and step in the same cycle: the press is judged against the pre-shift hit row. A hit note is removed before it shifts out, so no miss is counted.
- Hit in lane a and miss in lane b in the same cycle: score adds the hit points, then combo=0 (miss wins). Both pulses assert.
- song_end and step in the same cycle: that step still loads key_in; drain starts on the following steps.
- Reset mid-song: next-edge return to the reset values.
- A held button produces only one press.

## Configuration
- NOTE_JUDGE_GHOST_PENALTY_EN defined: a ghost press sets combo=0 and asserts miss_pulse. It does not change miss_count or score.
- NOTE_JUDGE_GHOST_PENALTY_EN undefined: ghost presses are ignored entirely.

## Structure
- Package note_judge_pkg holds:
  - default LANES, DEPTH and SCORE_W;
  - the state enum;
  - the combo bonus threshold (8) and point values (1, 2);
  - the saturation maxima.
- Sub-module lane_edge_detect: per-lane registered rising-edge detector for btn, reset to 0.

## Test plan
- Reset, start, step with key_in=5'b01000 → after 7 further steps the note sits in the hit row (field row 7 = 01000). Press btn[3] → hit_pulse, score=1, combo=1, row bit cleared.
- Note reaches the hit row, no press, next step → miss_pulse, miss_count=1, combo=0, score unchanged.
- Chain 9 hits → score=1·8+2=10, combo=9, max_combo=9. Then one miss → combo=0, max_combo=9.
- Press in the same cycle as the step that would shift out the note → hit only, miss_count unchanged.
- Ghost press with the macro defined → combo 3→0, miss_pulse=1, miss_count unchanged. With the macro undefined → no change at all.
- song_end, then 8 steps → state goes PLAY→DRAIN→DONE with field=0. A further start → PLAY with all counters 0.
